// File: rtl/bol_line_pingpong_pkg.sv
// Shared constants and types for the bolometer line ping-pong buffer.
package bol_line_pingpong_pkg;

  localparam int BOL_PIX_IN_ROW   = 640;
  localparam int BOL_NUMB_CHAN    = 4;
  localparam int BOL_DATA_W       = 14;
  localparam int BOL_ROW_IN_FRAME = 480;
  localparam int BOL_ROW_W        = 10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_STREAM,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/bol_line_ram.sv
// Two-bank line store: one write port, one registered read port (1-cycle latency).
// The {bank, word} address is folded onto a 2*WORDS deep array.
module bol_line_ram
  import bol_line_pingpong_pkg::*;
#(
  parameter int WORDS = BOL_PIX_IN_ROW / BOL_NUMB_CHAN,
  parameter int WIDTH = BOL_NUMB_CHAN * BOL_DATA_W,
  parameter int AW    = 8
) (
  input  logic             CLK,
  input  logic             wr_en,
  input  logic [AW:0]      wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW:0]      rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 * WORDS;

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic [AW:0] flat_addr(input logic [AW:0] a);
    logic [AW:0] word_part;
    word_part = {1'b0, a[AW-1:0]};
    return a[AW] ? ((AW+1)'(WORDS) + word_part) : word_part;
  endfunction

  // Storage write and registered read
  always_ff @(posedge CLK) begin
    if (wr_en) mem[flat_addr(wr_addr)] <= wr_data;
    if (rd_en) rd_data <= mem[flat_addr(rd_addr)];
  end

endmodule

// File: rtl/bol_line_pingpong.sv
// Ping-pong line buffer: captures readout words into two banks, commits a bank
// on each BUFER_CHANGE toggle, and streams committed lines one pixel per clock.
module bol_line_pingpong
  import bol_line_pingpong_pkg::*;
#(
  parameter int PIX_IN_ROW = BOL_PIX_IN_ROW,
  parameter int NUMB_CHAN  = BOL_NUMB_CHAN,
  parameter int DATA_W     = BOL_DATA_W
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUMB_CHAN*DATA_W-1:0] BL_DATA,
  input  logic                        BUF_IN_EN,
  input  logic                        BUFER_IN_VALID,
  input  logic                        BUFER_CHANGE,
  input  logic [BOL_ROW_W-1:0]        CNT_ROW,
  output logic [DATA_W-1:0]           PIX_OUT,
  output logic                        PIX_VALID,
  input  logic                        PIX_READY,
  output logic                        PIX_SOL,
  output logic                        PIX_EOL,
  output logic [BOL_ROW_W-1:0]        PIX_ROW,
  output logic                        LINE_ERR,
  output logic                        OVERFLOW
);

  localparam int WORDS  = PIX_IN_ROW / NUMB_CHAN;
  localparam int WORD_W = NUMB_CHAN * DATA_W;
  localparam int AW     = 8;
  localparam int CW     = (NUMB_CHAN > 1) ? $clog2(NUMB_CHAN) : 1;

  localparam logic [AW-1:0] WORDS_AW  = AW'(WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
  localparam logic [CW-1:0] CH_PRE    = CW'(NUMB_CHAN - 2);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUMB_CHAN - 1);

  // BUFER_CHANGE synchronizer; p2 is the delayed copy used for edge detect
  logic       chg_p0, chg_p1, chg_p2;
  logic [1:0] sync_cnt;
  logic       commit;

  // write side
  logic [AW-1:0]        wptr;
  logic                 wbank;
  logic                 long_flag;
  logic                 wr_blocked;
  logic [1:0]           full, full_nxt;
  logic [BOL_ROW_W-1:0] row_tag [2];
  logic                 wr_strobe, ram_we;
  logic                 line_clean, release_w, accept, drop_ovf, bad_line;

  // read side
  rd_state_t            state, nxt;
  logic                 rbank;
  logic [AW-1:0]        widx;
  logic [CW-1:0]        ch;
  logic [WORD_W-1:0]    sreg;
  logic                 pix_vld;
  logic [BOL_ROW_W-1:0] row_out;
  logic                 rd_en, load, shift, rd_done, px_take;
  logic [AW-1:0]        rd_word;
  logic [WORD_W-1:0]    rd_data;

  bol_line_ram #(
    .WORDS (WORDS),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (ram_we),
    .wr_addr ({wbank, wptr}),
    .wr_data (BL_DATA),
    .rd_en   (rd_en),
    .rd_addr ({rbank, rd_word}),
    .rd_data (rd_data)
  );

  // Stage p0..p2: synchronize BUFER_CHANGE; commits are armed only once the
  // pipeline holds real samples so a reset never fakes a toggle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chg_p0   <= 1'b0;
      chg_p1   <= 1'b0;
      chg_p2   <= 1'b0;
      sync_cnt <= 2'd0;
    end else begin
      chg_p0 <= BUFER_CHANGE;
      chg_p1 <= chg_p0;
      chg_p2 <= chg_p1;
      if (sync_cnt != 2'd3) sync_cnt <= sync_cnt + 2'd1;
    end
  end

  assign commit     = (sync_cnt == 2'd3) && (chg_p1 ^ chg_p2);
  assign wr_strobe  = !BUF_IN_EN && BUFER_IN_VALID;
  assign ram_we     = wr_strobe && (wptr < WORDS_AW) && !full[wbank];
  assign line_clean = (wptr == WORDS_AW) && !long_flag;
  assign release_w  = rd_done && (rbank == wbank);
  assign accept     = commit && line_clean && !wr_blocked && (!full[wbank] || release_w);
  assign drop_ovf   = commit && line_clean && !accept;
  assign bad_line   = commit && !line_clean;

  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rbank] = 1'b0;
    if (accept)  full_nxt[wbank] = 1'b1;
  end

  // Write stage: word counter, line classification and bank hand-over
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr       <= '0;
      wbank      <= 1'b0;
      long_flag  <= 1'b0;
      wr_blocked <= 1'b0;
      full       <= 2'b00;
      LINE_ERR   <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      full     <= full_nxt;
      LINE_ERR <= bad_line;
      if (drop_ovf) OVERFLOW <= 1'b1;
      if (commit) begin
        wptr       <= '0;
        long_flag  <= 1'b0;
        wr_blocked <= 1'b0;
        if (accept) wbank <= ~wbank;
      end else if (wr_strobe) begin
        if (wptr < WORDS_AW) begin
          wptr <= wptr + 1'b1;
          if (full[wbank]) wr_blocked <= 1'b1;
        end else begin
          long_flag <= 1'b1;
        end
      end
    end
  end

  // Row tag captured with the line at commit
  always_ff @(posedge CLK) begin
    if (commit) row_tag[wbank] <= CNT_ROW;
  end

  // Read FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= RD_IDLE;
    else          state <= nxt;
  end

  assign px_take = pix_vld && PIX_READY;

  // Read FSM next state and RAM fetch control
  always_comb begin
    nxt     = state;
    rd_en   = 1'b0;
    rd_word = '0;
    load    = 1'b0;
    shift   = 1'b0;
    rd_done = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rbank]) begin
          rd_en = 1'b1;
          nxt   = RD_FETCH;
        end
      end
      RD_FETCH: begin
        load = 1'b1;
        nxt  = RD_STREAM;
      end
      RD_STREAM: begin
        if (px_take) begin
          if (ch == CH_LAST) begin
            if (widx == LAST_WORD) nxt  = RD_DONE;
            else                   load = 1'b1;
          end else begin
            shift = 1'b1;
          end
          if ((ch == CH_PRE) && (widx != LAST_WORD)) begin
            rd_en   = 1'b1;
            rd_word = widx + 1'b1;
          end
        end
      end
      RD_DONE: begin
        rd_done = 1'b1;
        nxt     = RD_IDLE;
      end
      default: nxt = RD_IDLE;
    endcase
  end

  // Output stage: shift register, channel/word position and row tag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sreg    <= '0;
      ch      <= '0;
      widx    <= '0;
      pix_vld <= 1'b0;
      row_out <= '0;
      rbank   <= 1'b0;
    end else begin
      if (load) begin
        sreg    <= rd_data;
        ch      <= '0;
        pix_vld <= 1'b1;
        if (state == RD_FETCH) begin
          widx    <= '0;
          row_out <= row_tag[rbank];
        end else begin
          widx <= widx + 1'b1;
        end
      end else if (shift) begin
        sreg <= sreg >> DATA_W;
        ch   <= ch + 1'b1;
      end else if ((state == RD_STREAM) && (nxt == RD_DONE)) begin
        pix_vld <= 1'b0;
      end
      if (rd_done) rbank <= ~rbank;
    end
  end

  assign PIX_OUT   = sreg[DATA_W-1:0];
  assign PIX_VALID = pix_vld;
  assign PIX_SOL   = pix_vld && (ch == '0) && (widx == '0);
  assign PIX_EOL   = pix_vld && (ch == CH_LAST) && (widx == LAST_WORD);
  assign PIX_ROW   = row_out;

endmodule

// File: tb/tb_bol_line_pingpong.sv
// Scoreboard bench for bol_line_pingpong: lines are written with directed data,
// expected pixels are queued at commit, and a monitor checks the output stream.
module tb_bol_line_pingpong;

  localparam int NC   = 4;
  localparam int DW   = 14;
  localparam int NPIX = 640;
  localparam int NW   = NPIX / NC;

  logic             CLK;
  logic             RESET_N;
  logic [NC*DW-1:0] BL_DATA;
  logic             BUF_IN_EN;
  logic             BUFER_IN_VALID;
  logic             BUFER_CHANGE;
  logic [9:0]       CNT_ROW;
  logic [DW-1:0]    PIX_OUT;
  logic             PIX_VALID;
  logic             PIX_READY;
  logic             PIX_SOL;
  logic             PIX_EOL;
  logic [9:0]       PIX_ROW;
  logic             LINE_ERR;
  logic             OVERFLOW;

  bol_line_pingpong dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .BL_DATA        (BL_DATA),
    .BUF_IN_EN      (BUF_IN_EN),
    .BUFER_IN_VALID (BUFER_IN_VALID),
    .BUFER_CHANGE   (BUFER_CHANGE),
    .CNT_ROW        (CNT_ROW),
    .PIX_OUT        (PIX_OUT),
    .PIX_VALID      (PIX_VALID),
    .PIX_READY      (PIX_READY),
    .PIX_SOL        (PIX_SOL),
    .PIX_EOL        (PIX_EOL),
    .PIX_ROW        (PIX_ROW),
    .LINE_ERR       (LINE_ERR),
    .OVERFLOW       (OVERFLOW)
  );

  typedef struct packed {
    logic [9:0]    row;
    logic [DW-1:0] pix;
    logic          sol;
    logic          eol;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   lerr_cnt   = 0;
  int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random 50%

  logic          stall_q;
  logic [DW-1:0] h_pix;
  logic          h_sol, h_eol;
  logic [9:0]    h_row;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pix_val(input int mode, input int base, input int w, input int k);
    if (mode == 0) return DW'(w);
    return DW'(base + w * NC + k);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_words(input int nwords, input int mode, input int base);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < NC; k++) BL_DATA[k*DW +: DW] = pix_val(mode, base, w, k);
      BUF_IN_EN      = 1'b0;
      BUFER_IN_VALID = 1'b1;
      tick();
    end
    BUFER_IN_VALID = 1'b0;
    BUF_IN_EN      = 1'b1;
  endtask

  task automatic send_line(input int nwords, input int mode, input int base, input int row, input bit expect_out);
    exp_t e;
    send_words(nwords, mode, base);
    CNT_ROW = 10'(row);
    if (expect_out) begin
      for (int p = 0; p < NPIX; p++) begin
        e.row = 10'(row);
        e.pix = pix_val(mode, base, p / NC, p % NC);
        e.sol = (p == 0);
        e.eol = (p == NPIX - 1);
        sb.push_back(e);
      end
    end
    BUFER_CHANGE = ~BUFER_CHANGE;
    repeat (6) tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || PIX_VALID) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_out"},   32'(PIX_OUT),   32'd0);
    chk({tag, "_pix_valid"}, 32'(PIX_VALID), 32'd0);
    chk({tag, "_pix_sol"},   32'(PIX_SOL),   32'd0);
    chk({tag, "_pix_eol"},   32'(PIX_EOL),   32'd0);
    chk({tag, "_pix_row"},   32'(PIX_ROW),   32'd0);
    chk({tag, "_line_err"},  32'(LINE_ERR),  32'd0);
    chk({tag, "_overflow"},  32'(OVERFLOW),  32'd0);
  endtask

  // Downstream ready driver
  initial begin
    PIX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       PIX_READY = 1'b1;
        1:       PIX_READY = 1'b0;
        default: PIX_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each accepted pixel, checks holds on stalls
  initial begin
    exp_t e;
    stall_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        stall_q = 1'b0;
      end else begin
        if (LINE_ERR) lerr_cnt++;
        if (stall_q) begin
          checks++;
          if (!(PIX_VALID === 1'b1 && PIX_OUT === h_pix && PIX_SOL === h_sol &&
                PIX_EOL === h_eol && PIX_ROW === h_row)) begin
            failures++;
            $display("FAIL stall_hold actual=v%0b pix%0h sol%0b eol%0b row%0d required=v1 pix%0h sol%0b eol%0b row%0d",
                     PIX_VALID, PIX_OUT, PIX_SOL, PIX_EOL, PIX_ROW, h_pix, h_sol, h_eol, h_row);
          end
        end
        if (PIX_VALID && PIX_READY) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pixel actual=pix%0h row%0d required=no pixel", PIX_OUT, PIX_ROW);
          end else begin
            e = sb.pop_front();
            if (PIX_OUT !== e.pix || PIX_SOL !== e.sol || PIX_EOL !== e.eol || PIX_ROW !== e.row) begin
              failures++;
              $display("FAIL pixel actual=pix%0h sol%0b eol%0b row%0d required=pix%0h sol%0b eol%0b row%0d",
                       PIX_OUT, PIX_SOL, PIX_EOL, PIX_ROW, e.pix, e.sol, e.eol, e.row);
            end
          end
        end
        stall_q = PIX_VALID && !PIX_READY;
        h_pix   = PIX_OUT;
        h_sol   = PIX_SOL;
        h_eol   = PIX_EOL;
        h_row   = PIX_ROW;
      end
    end
  end

  // Directed stimulus
  initial begin
    RESET_N        = 1'b0;
    BL_DATA        = '0;
    BUF_IN_EN      = 1'b1;
    BUFER_IN_VALID = 1'b0;
    BUFER_CHANGE   = 1'b0;
    CNT_ROW        = '0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    RESET_N = 1'b1;
    repeat (4) tick();

    // single clean line, word w = {4{w}}, row 5
    send_line(NW, 0, 0, 5, 1'b1);
    wait_drain(2000);
    chk("clean_lerr", 32'(lerr_cnt), 32'd0);

    // short line: dropped with one error pulse, then a clean line
    send_line(NW - 1, 1, 100, 6, 1'b0);
    repeat (10) tick();
    chk("short_lerr", 32'(lerr_cnt), 32'd1);
    chk("short_novalid", 32'(PIX_VALID), 32'd0);
    send_line(NW, 1, 200, 7, 1'b1);
    wait_drain(2000);

    // long line: 161st strobe discarded, line dropped
    send_line(NW + 1, 1, 300, 8, 1'b0);
    repeat (20) tick();
    chk("long_lerr", 32'(lerr_cnt), 32'd2);
    chk("long_no_ovf", 32'(OVERFLOW), 32'd0);

    // overflow: three lines with downstream stalled
    ready_mode = 1;
    send_line(NW, 1, 1000, 0, 1'b1);
    send_line(NW, 1, 2000, 1, 1'b1);
    chk("ovf_before_third", 32'(OVERFLOW), 32'd0);
    send_line(NW, 1, 3000, 2, 1'b0);
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    chk("ovf_lerr", 32'(lerr_cnt), 32'd2);
    ready_mode = 0;
    wait_drain(3000);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // random backpressure over two back-to-back lines
    ready_mode = 2;
    send_line(NW, 1, 4000, 9, 1'b1);
    send_line(NW, 1, 5000, 10, 1'b1);
    wait_drain(8000);
    ready_mode = 0;

    // reset in the middle of a line
    send_words(NW / 2, 1, 6000);
    RESET_N = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (8) tick();
    chk("midrst_lerr", 32'(lerr_cnt), 32'd2);
    send_line(NW, 1, 7000, 11, 1'b1);
    wait_drain(2000);
    chk("final_lerr", 32'(lerr_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
